// File: rtl/layer_scan_controller.sv
// rtl/layer_scan_controller.sv - LED-cube layer scan driver with blanking and column-load handshake
module layer_scan_controller #(
  parameter int NUM_LAYERS   = 8,
  parameter int HOLD_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 16,
  localparam int LW = $clog2(NUM_LAYERS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  auto_en,
  input  logic [LW-1:0]         layer_i,
  input  logic                  stop,
  input  logic                  load_ack,
  output logic                  load_req,
  output logic [NUM_LAYERS-1:0] layer_out,
  output logic [LW-1:0]         cur_layer,
  output logic                  done,
  output logic                  frame_tick
);

  localparam int MAXC = (HOLD_CYCLES > BLANK_CYCLES) ? HOLD_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [LW-1:0] LAYER_LAST = LW'(NUM_LAYERS - 1);
  localparam logic [LW:0]   LAYER_LIM  = (LW+1)'(NUM_LAYERS);
  localparam logic [NUM_LAYERS-1:0] ONE_HOT0 = NUM_LAYERS'(1);

  typedef enum logic [1:0] {IDLE, BLANK, ACTIVE} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          auto_mode, auto_d;
  logic          stop_pend, stop_d;
  logic          ack_seen, ack_d;
  logic [LW-1:0] cur_layer_d;
  logic          load_req_d, done_d, frame_tick_d;
  logic [NUM_LAYERS-1:0] layer_out_d;

  logic start_ok, blank_done, hold_done, finish;

  assign start_ok   = start && ({1'b0, layer_i} < LAYER_LIM);
  assign blank_done = (cnt >= BLANK_LAST) && (ack_seen || load_ack);
  assign hold_done  = (cnt == HOLD_LAST);
  assign finish     = !auto_mode || stop_pend || stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      auto_mode  <= 1'b0;
      stop_pend  <= 1'b0;
      ack_seen   <= 1'b0;
      cur_layer  <= '0;
      load_req   <= 1'b0;
      layer_out  <= '0;
      done       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      auto_mode  <= auto_d;
      stop_pend  <= stop_d;
      ack_seen   <= ack_d;
      cur_layer  <= cur_layer_d;
      load_req   <= load_req_d;
      layer_out  <= layer_out_d;
      done       <= done_d;
      frame_tick <= frame_tick_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start_ok) state_d = BLANK;
      BLANK:   if (blank_done) state_d = ACTIVE;
      ACTIVE:  if (hold_done) state_d = finish ? IDLE : BLANK;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so every output is a flop.
  always_comb begin
    cnt_d        = cnt;
    auto_d       = auto_mode;
    ack_d        = ack_seen;
    cur_layer_d  = cur_layer;
    frame_tick_d = 1'b0;
    stop_d       = stop_pend || ((state != IDLE) && stop);
    case (state)
      IDLE: begin
        if (start_ok) begin
          cur_layer_d = layer_i;
          auto_d      = auto_en;
          cnt_d       = '0;
          ack_d       = 1'b0;
        end
      end
      BLANK: begin
        ack_d = ack_seen || load_ack;
        if (blank_done) cnt_d = '0;
        else if (cnt < BLANK_LAST) cnt_d = cnt + CW'(1);
      end
      ACTIVE: begin
        if (hold_done) begin
          cnt_d = '0;
          ack_d = 1'b0;
          if (!finish) begin
            cur_layer_d  = (cur_layer == LAYER_LAST) ? '0 : cur_layer + LW'(1);
            frame_tick_d = (cur_layer == LAYER_LAST);
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: cnt_d = '0;
    endcase
    if (state_d == IDLE) stop_d = 1'b0;
    load_req_d  = (state_d == BLANK) && !ack_d;
    layer_out_d = (state_d == ACTIVE) ? (ONE_HOT0 << cur_layer_d) : '0;
    done_d      = (state_d == IDLE);
  end

endmodule

// File: tb/tb_layer_scan_controller.sv
// tb/tb_layer_scan_controller.sv - directed bench for layer_scan_controller (4 layers, hold 3, blank 2)
module tb_layer_scan_controller;

  logic       clk = 1'b0;
  logic       rst_n, start, auto_en, stop, load_ack;
  logic [1:0] layer_i;
  logic       load_req, done, frame_tick;
  logic [3:0] layer_out;
  logic [1:0] cur_layer;

  logic       start5;
  logic [2:0] layer5, cur_layer5;
  logic       load_req5, done5, frame_tick5;
  logic [4:0] layer_out5;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  layer_scan_controller #(.NUM_LAYERS(4), .HOLD_CYCLES(3), .BLANK_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .auto_en(auto_en), .layer_i(layer_i),
    .stop(stop), .load_ack(load_ack), .load_req(load_req), .layer_out(layer_out),
    .cur_layer(cur_layer), .done(done), .frame_tick(frame_tick)
  );

  layer_scan_controller #(.NUM_LAYERS(5), .HOLD_CYCLES(3), .BLANK_CYCLES(2)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .auto_en(auto_en), .layer_i(layer5),
    .stop(stop), .load_ack(load_ack), .load_req(load_req5), .layer_out(layer_out5),
    .cur_layer(cur_layer5), .done(done5), .frame_tick(frame_tick5)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [3:0] exp_lo2 [1:6] = '{4'h0, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0};
  logic       exp_dn2 [1:6] = '{0, 0, 0, 0, 0, 1};
  logic       exp_lr2 [1:6] = '{1, 0, 0, 0, 0, 0};
  logic [3:0] exp_lo5 [1:12] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0,
                                 4'h2, 4'h2, 4'h2, 4'h0, 4'h0};

  initial begin
    int k, lay, lit, waited;
    logic [3:0] exp_lo;
    rst_n = 1'b0; start = 1'b0; auto_en = 1'b0; stop = 1'b0; load_ack = 1'b1;
    layer_i = '0; start5 = 1'b0; layer5 = '0;

    // reset
    @(negedge clk);
    check_eq("rst_layer_out", 32'(layer_out), 32'h0);
    check_eq("rst_done", 32'(done), 32'h1);
    check_eq("rst_load_req", 32'(load_req), 32'h0);
    check_eq("rst_cur_layer", 32'(cur_layer), 32'h0);
    check_eq("rst_frame_tick", 32'(frame_tick), 32'h0);
    rst_n = 1'b1;
    step();

    // single shot, layer 2
    start = 1'b1; auto_en = 1'b0; layer_i = 2'd2;
    step();
    start = 1'b0; layer_i = 2'd0;
    for (int c = 1; c <= 6; c++) begin
      check_eq($sformatf("single_lo_c%0d", c), 32'(layer_out), 32'(exp_lo2[c]));
      check_eq($sformatf("single_done_c%0d", c), 32'(done), 32'(exp_dn2[c]));
      check_eq($sformatf("single_req_c%0d", c), 32'(load_req), 32'(exp_lr2[c]));
      check_eq($sformatf("single_ft_c%0d", c), 32'(frame_tick), 32'h0);
      if (c < 6) step();
    end
    step();

    // auto scan from layer 3
    start = 1'b1; auto_en = 1'b1; layer_i = 2'd3;
    step();
    start = 1'b0; auto_en = 1'b0; layer_i = 2'd1;
    for (int c = 1; c <= 26; c++) begin
      k = c - 1;
      lay = (3 + k / 5) % 4;
      exp_lo = (k % 5 >= 2) ? (4'h1 << lay) : 4'h0;
      check_eq($sformatf("auto_lo_c%0d", c), 32'(layer_out), 32'(exp_lo));
      check_eq($sformatf("auto_ft_c%0d", c), 32'(frame_tick),
               32'((k % 5 == 0) && (lay == 0) && (k > 0)));
      if (c < 26) step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    lit = 0; waited = 0;
    while (!done && waited < 20) begin
      if (layer_out == 4'h1) lit++;
      step();
      waited++;
    end
    check_eq("auto_stop_done", 32'(done), 32'h1);
    check_eq("auto_stop_lit_cycles", 32'(lit), 32'd3);
    step();

    // slow ack, single layer 1
    load_ack = 1'b0;
    start = 1'b1; auto_en = 1'b0; layer_i = 2'd1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      check_eq($sformatf("slow_req_c%0d", c), 32'(load_req), 32'h1);
      check_eq($sformatf("slow_lo_c%0d", c), 32'(layer_out), 32'h0);
      if (c == 5) load_ack = 1'b1;
      step();
      load_ack = 1'b0;
    end
    for (int c = 6; c <= 8; c++) begin
      check_eq($sformatf("slow_lo_c%0d", c), 32'(layer_out), 32'h2);
      check_eq($sformatf("slow_req_c%0d", c), 32'(load_req), 32'h0);
      step();
    end
    check_eq("slow_done", 32'(done), 32'h1);
    check_eq("slow_lo_end", 32'(layer_out), 32'h0);
    load_ack = 1'b1;
    step();

    // stop in 2nd active cycle of layer 1, with starts while busy
    start = 1'b1; auto_en = 1'b1; layer_i = 2'd0;
    step();
    start = 1'b0; auto_en = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      check_eq($sformatf("stop_lo_c%0d", c), 32'(layer_out), 32'(exp_lo5[c]));
      check_eq($sformatf("stop_done_c%0d", c), 32'(done), 32'(c >= 11));
      start = (c == 4 || c == 7);
      layer_i = 2'd3;
      stop = (c == 9);
      step();
      start = 1'b0; stop = 1'b0;
    end
    check_eq("stop_cur_layer", 32'(cur_layer), 32'h1);

    // asynchronous abort mid-active
    start = 1'b1; auto_en = 1'b0; layer_i = 2'd3;
    step();
    start = 1'b0;
    step(); step(); step();
    check_eq("abort_pre_lo", 32'(layer_out), 32'h8);
    #1 rst_n = 1'b0;
    #1;
    check_eq("abort_lo", 32'(layer_out), 32'h0);
    check_eq("abort_done", 32'(done), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // out-of-range start on a 5-layer build
    start5 = 1'b1; layer5 = 3'd5;
    step();
    start5 = 1'b0;
    step();
    check_eq("range_done", 32'(done5), 32'h1);
    check_eq("range_req", 32'(load_req5), 32'h0);
    check_eq("range_cur", 32'(cur_layer5), 32'h0);
    start5 = 1'b1; layer5 = 3'd4;
    step();
    start5 = 1'b0;
    check_eq("range_ok_req", 32'(load_req5), 32'h1);
    check_eq("range_ok_cur", 32'(cur_layer5), 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
